// File: rtl/seg_pkg.sv
// seg_pkg: shared types, font table and shift-word builder for the segment scanner
package seg_pkg;
  typedef struct packed {logic blank; logic dp; logic [3:0] hex;} seg_ent_t;
  typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_LATCH} seg_st_t;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam seg_ent_t SEG_ENT_OFF = 6'h20;
  localparam logic [5:0] PH_LATCH = 6'd33;
  localparam logic [5:0] PH_END = 6'd34;
  localparam logic [7:0] SEG_FONT [16] = '{
    8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e
  };
  function automatic logic [15:0] seg_word(seg_ent_t e, logic [2:0] d);
    logic [7:0] f;
    f = SEG_FONT[e.hex];
    return {e.blank ? SEG_BLANK : {f[7] & ~e.dp, f[6:0]}, 8'd1 << d};
  endfunction
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: two-requester write port into the digit frame buffer
interface seg_scan_ctrl_if;
  logic wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [2:0] wr0_addr, wr1_addr;
  seg_pkg::seg_ent_t wr0_data, wr1_data;
  modport master(
    output wr0_valid, wr0_addr, wr0_data, wr1_valid, wr1_addr, wr1_data,
    input wr0_ready, wr1_ready
  );
  modport slave(
    input wr0_valid, wr0_addr, wr0_data, wr1_valid, wr1_addr, wr1_data,
    output wr0_ready, wr1_ready
  );
endinterface

// File: rtl/seg_tick.sv
// seg_tick: prescaler emitting a one-cycle tick every HALF_DIV clocks
module seg_tick #(
  parameter int HALF_DIV = 512
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = $clog2(HALF_DIV);
  logic [CW-1:0] r_cnt;
  assign tick = r_cnt == CW'(HALF_DIV - 1);
  always_ff @(posedge clk)
    r_cnt <= (rst || tick) ? '0 : r_cnt + CW'(1);
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: arbitrated 8-digit frame buffer scanned out to a 74HC595 chain
module seg_scan_ctrl import seg_pkg::*; #(
  parameter int HALF_DIV = 512,
  parameter int NDIG = 8
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  wr,
  output logic            o_segdata,
  output logic            o_shclk,
  output logic            o_stclk,
  output logic            o_frame_done
);
  seg_st_t r_st, w_st;
  seg_ent_t r_buf [NDIG];
  logic r_rr, w_g0, w_g1, w_tick;
  logic [5:0] r_ph, w_ph, w_np;
  logic [2:0] r_dig, w_dig;
  logic [15:0] r_sh, w_sh, w_word;
  logic r_sd, w_sd, r_sc, w_sc, r_lc, w_lc, r_fd, w_fd;
  seg_tick #(.HALF_DIV(HALF_DIV)) u_tick (.clk(clk), .rst(rst), .tick(w_tick));
  assign w_g0 = !rst && wr.wr0_valid && (!wr.wr1_valid || !r_rr);
  assign w_g1 = !rst && wr.wr1_valid && (!wr.wr0_valid || r_rr);
  assign wr.wr0_ready = w_g0;
  assign wr.wr1_ready = w_g1;
  assign w_word = seg_word(r_buf[r_dig], r_dig);
  assign w_np = r_ph + 6'd1;
  assign o_segdata = r_sd;
  assign o_shclk = r_sc;
  assign o_stclk = r_lc;
  assign o_frame_done = r_fd;
  always_comb begin
    w_st = r_st;
    w_ph = r_ph;
    w_dig = r_dig;
    w_sh = r_sh;
    w_sd = r_sd;
    w_sc = r_sc;
    w_lc = r_lc;
    w_fd = 1'b0;
    case (r_st)
      S_LOAD: begin
        w_sh = w_word;
        w_st = S_SHIFT;
        w_ph = (r_ph == PH_END) ? 6'd1 : 6'd0;
        w_sd = (r_ph == PH_END) ? w_word[15] : r_sd;
      end
      S_SHIFT: if (w_tick) begin
        w_ph = w_np;
        w_st = (w_np == PH_LATCH) ? S_LATCH : S_SHIFT;
        w_sc = !w_np[0];
        w_lc = w_np == PH_LATCH;
        w_sd = (w_np[0] && w_np != PH_LATCH) ? r_sh[~w_np[4:1]] : r_sd;
      end
      S_LATCH: if (w_tick) begin
        w_ph = (r_ph == PH_END) ? r_ph : w_np;
        w_st = (r_ph == PH_END) ? S_LOAD : S_LATCH;
        w_lc = r_ph != PH_END;
        w_dig = (r_ph == PH_END) ? r_dig + 3'd1 : r_dig;
        w_fd = r_ph == PH_END && r_dig == 3'(NDIG - 1);
      end
      default: w_st = S_LOAD;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_rr <= 1'b0;
      for (int i = 0; i < NDIG; i++) r_buf[i] <= SEG_ENT_OFF;
      r_st <= S_LOAD;
      r_ph <= '0;
      r_dig <= '0;
      r_sh <= '0;
      r_sd <= 1'b0;
      r_sc <= 1'b0;
      r_lc <= 1'b0;
      r_fd <= 1'b0;
    end else begin
      r_rr <= (wr.wr0_valid && wr.wr1_valid) ? !r_rr : r_rr;
      if (w_g0) r_buf[wr.wr0_addr] <= wr.wr0_data;
      if (w_g1) r_buf[wr.wr1_addr] <= wr.wr1_data;
      r_st <= w_st;
      r_ph <= w_ph;
      r_dig <= w_dig;
      r_sh <= w_sh;
      r_sd <= w_sd;
      r_sc <= w_sc;
      r_lc <= w_lc;
      r_fd <= w_fd;
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench with a 595 chain model
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic segdata, shclk, stclk, fd;
  logic [15:0] sr = '0;
  logic [15:0] lat = '0;
  logic [15:0] w;
  int nlat = 0;
  int nfd = 0;
  int fd_at = -1;
  int n_chk = 0;
  int n_fail = 0;
  int base = 0;
  always #5 clk = ~clk;
  seg_scan_ctrl_if wr();
  seg_scan_ctrl #(.HALF_DIV(2), .NDIG(8)) dut (
    .clk(clk), .rst(rst), .wr(wr),
    .o_segdata(segdata), .o_shclk(shclk), .o_stclk(stclk), .o_frame_done(fd)
  );
  always @(posedge shclk) sr <= {sr[14:0], segdata};
  always @(posedge stclk) begin
    lat = sr;
    nlat = nlat + 1;
  end
  always @(posedge clk)
    if (fd) begin
      nfd = nfd + 1;
      fd_at = nlat;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic next_latch(output logic [15:0] q);
    int s = nlat;
    int t = 0;
    while (nlat == s && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("latch_wait", 32'(nlat != s), 1);
    q = lat;
  endtask
  task automatic wait_digit(input int d, output logic [15:0] q);
    int k = 0;
    do begin
      next_latch(q);
      k++;
    end while (((nlat - base - 1) % 8) != d && k < 9);
  endtask
  task automatic wr_one(input int r, input logic [2:0] a, input logic [5:0] dt);
    @(negedge clk);
    if (r == 0) begin
      wr.wr0_valid = 1'b1;
      wr.wr0_addr = a;
      wr.wr0_data = dt;
    end else begin
      wr.wr1_valid = 1'b1;
      wr.wr1_addr = a;
      wr.wr1_data = dt;
    end
    #1;
    chk($sformatf("wr%0d_ready", r), r == 0 ? wr.wr0_ready : wr.wr1_ready, 1);
    @(negedge clk);
    wr.wr0_valid = 1'b0;
    wr.wr1_valid = 1'b0;
  endtask
  initial begin
    int k, rises, t;
    logic p;
    wr.wr0_valid = 1'b0;
    wr.wr1_valid = 1'b0;
    wr.wr0_addr = '0;
    wr.wr1_addr = '0;
    wr.wr0_data = '0;
    wr.wr1_data = '0;
    repeat (3) @(negedge clk);
    wr.wr0_valid = 1'b1;
    wr.wr1_valid = 1'b1;
    #1;
    chk("rst_ready0", wr.wr0_ready, 0);
    chk("rst_ready1", wr.wr1_ready, 0);
    chk("rst_outs", {segdata, shclk, stclk, fd}, 0);
    wr.wr0_valid = 1'b0;
    wr.wr1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (!shclk && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("first_rise", k, 4);
    base = nlat;
    for (int d = 0; d < 8; d++) begin
      wait_digit(d, w);
      chk($sformatf("blank_d%0d", d), w, {8'hFF, 8'(1 << d)});
    end
    k = 0;
    while (nfd == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("frame_done_cnt", nfd, 1);
    chk("frame_done_pos", fd_at - base, 8);
    wr_one(0, 3'd3, 6'h05);
    wait_digit(3, w);
    chk("hex5_d3", w, 16'h9208);
    wr_one(0, 3'd3, 6'h15);
    wait_digit(3, w);
    chk("hex5_dp_d3", w, 16'h1208);
    @(negedge clk);
    wr.wr0_valid = 1'b1; wr.wr0_addr = 3'd0; wr.wr0_data = 6'h01;
    wr.wr1_valid = 1'b1; wr.wr1_addr = 3'd1; wr.wr1_data = 6'h02;
    #1;
    chk("arb1", {wr.wr0_ready, wr.wr1_ready}, 2'b10);
    @(negedge clk);
    wr.wr0_addr = 3'd4; wr.wr0_data = 6'h04;
    #1;
    chk("arb2", {wr.wr0_ready, wr.wr1_ready}, 2'b01);
    @(negedge clk);
    wr.wr1_addr = 3'd5; wr.wr1_data = 6'h06;
    #1;
    chk("arb3", {wr.wr0_ready, wr.wr1_ready}, 2'b10);
    @(negedge clk);
    wr.wr0_addr = 3'd6; wr.wr0_data = 6'h07;
    #1;
    chk("arb4", {wr.wr0_ready, wr.wr1_ready}, 2'b01);
    @(negedge clk);
    wr.wr1_valid = 1'b0;
    #1;
    chk("arb_single", {wr.wr0_ready, wr.wr1_ready}, 2'b10);
    @(negedge clk);
    wr.wr0_valid = 1'b0;
    wait_digit(7, w);
    wait_digit(0, w);
    chk("arb_d0", w, 16'hF901);
    wait_digit(1, w);
    chk("arb_d1", w, 16'hA402);
    wait_digit(3, w);
    chk("keep_d3", w, 16'h1208);
    wait_digit(4, w);
    chk("arb_d4", w, 16'h9910);
    wait_digit(5, w);
    chk("arb_d5", w, 16'h8220);
    wait_digit(6, w);
    chk("arb_d6", w, 16'hF840);
    wait_digit(1, w);
    repeat (10) @(negedge clk);
    wr_one(0, 3'd2, 6'h08);
    wait_digit(2, w);
    chk("live_d2_old", w, 16'hFF04);
    wait_digit(2, w);
    chk("live_d2_new", w, 16'h8004);
    wr_one(1, 3'd7, 6'h2F);
    wait_digit(7, w);
    chk("blank_over_hex", w, 16'hFF80);
    wait_digit(4, w);
    rises = 0;
    t = 0;
    p = shclk;
    while (!(rises == 9 && !shclk) && t < 300) begin
      @(negedge clk);
      if (shclk && !p) rises++;
      p = shclk;
      t++;
    end
    chk("reach_bit9", rises, 9);
    rst = 1'b1;
    k = nlat;
    @(posedge clk);
    #1;
    chk("midrst_outs", {segdata, shclk, stclk, fd}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_stclk", nlat, k);
    base = nlat;
    for (int d = 0; d < 8; d++) begin
      wait_digit(d, w);
      chk($sformatf("post_rst_d%0d", d), w, {8'hFF, 8'(1 << d)});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
